// File: rtl/nonogram_controller.sv
// Phase sequencer for the nonogram solver: RECEIVE -> SOLVE -> TRANSMIT,
// with FIFO arbitration, phase-boundary latches, watchdog and error handling.
module nonogram_controller #(
    parameter int MAX_ROWS        = 11,
    parameter int MAX_COLS        = 11,
    parameter int MAX_NUM_OPTIONS = 84,
    parameter int TIMEOUT_CYCLES  = 50_000_000,
    localparam int MAX_DIM = (MAX_ROWS > MAX_COLS) ? MAX_ROWS : MAX_COLS,
    localparam int DIM_W   = $clog2(MAX_DIM + 1),
    localparam int OPT_W   = $clog2(MAX_NUM_OPTIONS + 1),
    localparam int LINES   = MAX_ROWS + MAX_COLS,
    localparam int CELLS   = MAX_ROWS * MAX_COLS
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   parsed,
    input  logic                   parse_write,
    input  logic                   first_read,
    input  logic [15:0]            parse_line,
    input  logic [DIM_W-1:0]       m_in,
    input  logic [DIM_W-1:0]       n_in,
    input  logic [LINES*OPT_W-1:0] options_in,
    input  logic                   solve_write,
    input  logic                   solve_next,
    input  logic [15:0]            solve_line,
    input  logic                   solved,
    input  logic [CELLS-1:0]       solution_in,
    input  logic                   assembled,
    input  logic                   fifo_full,
    input  logic                   fifo_empty,
    input  logic                   err_clear,
    output logic                   fifo_wr_en,
    output logic                   fifo_rd_en,
    output logic [15:0]            fifo_din,
    output logic [DIM_W-1:0]       m_out,
    output logic [DIM_W-1:0]       n_out,
    output logic [LINES*OPT_W-1:0] options_out,
    output logic [CELLS-1:0]       solution_out,
    output logic                   solve_start,
    output logic                   assemble_start,
    output logic                   sub_clear,
    output logic [1:0]             state_out,
    output logic [1:0]             error_code,
    output logic [7:0]             board_count,
    output logic [7:0]             led
);

    localparam int WD_W = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        RECEIVE  = 2'd0,
        SOLVE    = 2'd1,
        TRANSMIT = 2'd2,
        ERROR    = 2'd3
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_DIM     = 2'd1;
    localparam logic [1:0] ERR_FIFO    = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    state_t            state;
    state_t            next_state;
    logic [1:0]        next_err;
    logic [WD_W-1:0]   watchdog;
    logic              wr_req;
    logic              rd_req;
    logic              overflow;
    logic              underflow;
    logic              dims_ok;
    logic              latch_dims;
    logic              latch_sol;
    logic              count_inc;

    // FIFO ownership follows the phase; full/empty gate the strobes.
    always_comb begin
        wr_req   = 1'b0;
        rd_req   = 1'b0;
        fifo_din = parse_line;
        case (state)
            RECEIVE: begin
                wr_req = parse_write;
                rd_req = first_read;
            end
            SOLVE: begin
                wr_req   = solve_write;
                rd_req   = solve_next;
                fifo_din = solve_line;
            end
            default: ;
        endcase
        fifo_wr_en = wr_req & ~fifo_full;
        fifo_rd_en = rd_req & ~fifo_empty;
        overflow   = wr_req & fifo_full;
        underflow  = rd_req & fifo_empty & (state == SOLVE);
    end

    assign dims_ok = (m_in >= DIM_W'(1)) && (m_in <= DIM_W'(MAX_ROWS))
                  && (n_in >= DIM_W'(1)) && (n_in <= DIM_W'(MAX_COLS));

    // Next-state, next error code and latch enables for the phase FSM.
    always_comb begin
        next_state = state;
        next_err   = error_code;
        latch_dims = 1'b0;
        latch_sol  = 1'b0;
        count_inc  = 1'b0;
        case (state)
            RECEIVE: begin
                if (parsed && dims_ok) begin
                    latch_dims = 1'b1;
                    next_state = SOLVE;
                end else if (parsed) begin
                    next_state = ERROR;
                    next_err   = ERR_DIM;
                end else if (overflow) begin
                    next_state = ERROR;
                    next_err   = ERR_FIFO;
                end
            end
            SOLVE: begin
                if (solved) begin
                    latch_sol  = 1'b1;
                    next_state = TRANSMIT;
                end else if (overflow || underflow) begin
                    next_state = ERROR;
                    next_err   = ERR_FIFO;
                end else if (watchdog == WD_W'(TIMEOUT_CYCLES - 1)) begin
                    next_state = ERROR;
                    next_err   = ERR_TIMEOUT;
                end
            end
            TRANSMIT: begin
                if (assembled) begin
                    count_inc  = 1'b1;
                    next_state = RECEIVE;
                end
            end
            ERROR: begin
                if (err_clear) begin
                    next_state = RECEIVE;
                    next_err   = ERR_NONE;
                end
            end
            default: next_state = RECEIVE;
        endcase
    end

    // Phase register, error code and one-cycle phase-entry pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= RECEIVE;
            error_code     <= ERR_NONE;
            solve_start    <= 1'b0;
            assemble_start <= 1'b0;
            sub_clear      <= 1'b0;
        end else begin
            state          <= next_state;
            error_code     <= next_err;
            solve_start    <= (next_state == SOLVE) && (state != SOLVE);
            assemble_start <= (next_state == TRANSMIT) && (state != TRANSMIT);
            sub_clear      <= (next_state == RECEIVE)
                           && (state == TRANSMIT || state == ERROR);
        end
    end

    // Board data captured only at phase boundaries.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_out        <= '0;
            n_out        <= '0;
            options_out  <= '0;
            solution_out <= '0;
        end else begin
            if (latch_dims) begin
                m_out       <= m_in;
                n_out       <= n_in;
                options_out <= options_in;
            end
            if (latch_sol) begin
                solution_out <= solution_in;
            end
        end
    end

    // Solve watchdog: zero on SOLVE entry, counts every SOLVE cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            watchdog <= '0;
        end else if (state != SOLVE) begin
            watchdog <= '0;
        end else begin
            watchdog <= watchdog + WD_W'(1);
        end
    end

    // Completed-board counter, wraps naturally at 8 bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            board_count <= '0;
        end else if (count_inc) begin
            board_count <= board_count + 8'd1;
        end
    end

    assign state_out = state;
    assign led       = {state_out, error_code, board_count[3:0]};

endmodule
